// File: rtl/rt_stage_if.sv
// ROB-head to retire-stage bundle: retire candidates in, AMT writes,
// free-list returns and rollback out.
interface rt_stage_if #(
  parameter int unsigned C_RT_NUM         = 2,
  parameter int unsigned C_ARCH_IDX_WIDTH = 5,
  parameter int unsigned C_TAG_IDX_WIDTH  = 6
);
  localparam int unsigned C_NUM_WIDTH = $clog2(C_RT_NUM + 1);

  logic [C_RT_NUM-1:0]                       rob_valid_i;
  logic [C_RT_NUM-1:0]                       rob_complete_i;
  logic [C_RT_NUM-1:0]                       rob_br_mispred_i;
  logic [C_RT_NUM-1:0][C_ARCH_IDX_WIDTH-1:0] rob_rd_i;
  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0]  rob_tag_i;
  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0]  rob_tag_old_i;
  logic                                      rob_empty_i;

  logic [C_NUM_WIDTH-1:0]                    rt_retire_num_o;
  logic [C_RT_NUM-1:0]                       rt_amt_wr_en_o;
  logic [C_RT_NUM-1:0][C_ARCH_IDX_WIDTH-1:0] rt_amt_rd_o;
  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0]  rt_amt_tag_o;
  logic [C_RT_NUM-1:0]                       rt_fl_valid_o;
  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0]  rt_fl_tag_o;
  logic                                      rollback_o;
  logic [31:0]                               rt_retired_cnt_o;

  modport master (
    output rob_valid_i, rob_complete_i, rob_br_mispred_i,
    output rob_rd_i, rob_tag_i, rob_tag_old_i, rob_empty_i,
    input  rt_retire_num_o, rt_amt_wr_en_o, rt_amt_rd_o, rt_amt_tag_o,
    input  rt_fl_valid_o, rt_fl_tag_o, rollback_o, rt_retired_cnt_o
  );

  modport slave (
    input  rob_valid_i, rob_complete_i, rob_br_mispred_i,
    input  rob_rd_i, rob_tag_i, rob_tag_old_i, rob_empty_i,
    output rt_retire_num_o, rt_amt_wr_en_o, rt_amt_rd_o, rt_amt_tag_o,
    output rt_fl_valid_o, rt_fl_tag_o, rollback_o, rt_retired_cnt_o
  );
endinterface

// File: rtl/rt_stage.sv
// Retire stage: in-order retirement from the ROB head into the AMT and free
// list, with rollback sequencing after a mispredicted branch retires.
module rt_stage #(
  parameter int unsigned C_RT_NUM         = 2,
  parameter int unsigned C_ARCH_IDX_WIDTH = 5,
  parameter int unsigned C_TAG_IDX_WIDTH  = 6
) (
  input logic    clk_i,
  input logic    rst_i,
  rt_stage_if.slave rt
);
  localparam int unsigned C_NUM_WIDTH = $clog2(C_RT_NUM + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_WB,
    S_ROLLBACK,
    S_RECOVER
  } state_t;

  state_t state_q, state_nxt;

  logic [C_RT_NUM-1:0]                       retire;
  logic                                      lane_ok;
  logic                                      mispred_hit;
  logic [C_NUM_WIDTH-1:0]                    retire_cnt;
  logic [C_RT_NUM-1:0]                       amt_wr_nxt;
  logic [C_RT_NUM-1:0]                       fl_valid_nxt;

  logic [C_RT_NUM-1:0]                       amt_wr_q;
  logic [C_RT_NUM-1:0][C_ARCH_IDX_WIDTH-1:0] amt_rd_q;
  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0]  amt_tag_q;
  logic [C_RT_NUM-1:0]                       fl_valid_q;
  logic [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0]  fl_tag_q;
  logic                                      rollback_q;
  logic [31:0]                               retired_cnt_q;

  // A mispredicted lane retires itself but closes the window for younger lanes.
  always_comb begin
    retire      = '0;
    lane_ok     = 1'b1;
    mispred_hit = 1'b0;
    if (state_q == S_RUN) begin
      for (int unsigned i = 0; i < C_RT_NUM; i++) begin
        lane_ok   = lane_ok & rt.rob_valid_i[i] & rt.rob_complete_i[i];
        retire[i] = lane_ok;
        if (lane_ok && rt.rob_br_mispred_i[i]) begin
          mispred_hit = 1'b1;
        end
        lane_ok = lane_ok & ~rt.rob_br_mispred_i[i];
      end
    end
  end

  always_comb begin
    retire_cnt = '0;
    for (int unsigned i = 0; i < C_RT_NUM; i++) begin
      retire_cnt = retire_cnt + C_NUM_WIDTH'(retire[i]);
    end
  end

  // Older writes to an rd that a younger retiring lane also writes are dropped;
  // the free-list return of every retiring lane is kept.
  always_comb begin
    amt_wr_nxt   = '0;
    fl_valid_nxt = '0;
    for (int unsigned i = 0; i < C_RT_NUM; i++) begin
      fl_valid_nxt[i] = retire[i] && (rt.rob_rd_i[i] != '0);
      amt_wr_nxt[i]   = fl_valid_nxt[i];
      for (int unsigned j = i + 1; j < C_RT_NUM; j++) begin
        if (retire[j] && (rt.rob_rd_i[j] == rt.rob_rd_i[i])) begin
          amt_wr_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_RUN:      if (mispred_hit) state_nxt = S_WB;
      S_WB:       state_nxt = S_ROLLBACK;
      S_ROLLBACK: state_nxt = S_RECOVER;
      S_RECOVER:  if (rt.rob_empty_i) state_nxt = S_RUN;
      default:    state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_RUN;
      amt_wr_q      <= '0;
      amt_rd_q      <= '0;
      amt_tag_q     <= '0;
      fl_valid_q    <= '0;
      fl_tag_q      <= '0;
      rollback_q    <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_nxt;
      amt_wr_q      <= amt_wr_nxt;
      amt_rd_q      <= rt.rob_rd_i;
      amt_tag_q     <= rt.rob_tag_i;
      fl_valid_q    <= fl_valid_nxt;
      fl_tag_q      <= rt.rob_tag_old_i;
      rollback_q    <= (state_nxt == S_ROLLBACK);
      retired_cnt_q <= retired_cnt_q + 32'(retire_cnt);
    end
  end

  // The pop count is combinational, so it is masked while reset is held.
  assign rt.rt_retire_num_o  = rst_i ? retire_cnt : '0;
  assign rt.rt_amt_wr_en_o   = amt_wr_q;
  assign rt.rt_amt_rd_o      = amt_rd_q;
  assign rt.rt_amt_tag_o     = amt_tag_q;
  assign rt.rt_fl_valid_o    = fl_valid_q;
  assign rt.rt_fl_tag_o      = fl_tag_q;
  assign rt.rollback_o       = rollback_q;
  assign rt.rt_retired_cnt_o = retired_cnt_q;
endmodule

// File: tb/tb_rt_stage.sv
// Scoreboard bench for rt_stage: random and directed ROB-head traffic
// against a cycle-level reference of the retire rules.
module tb_rt_stage;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 5;
  localparam int unsigned TW = 6;

  typedef struct {
    logic [1:0]         num;
    logic [1:0]         wr;
    logic [1:0]         fl;
    logic [1:0][AW-1:0] rd;
    logic [1:0][TW-1:0] tag;
    logic [1:0][TW-1:0] ftag;
    logic               rb;
    logic [31:0]        cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  // Reference state: blocked counts cycles since a mispredict retired (-1 = free to retire).
  int                 blocked;
  logic [31:0]        m_cnt;
  logic [1:0]         p_wr, p_fl;
  logic [1:0][AW-1:0] p_rd;
  logic [1:0][TW-1:0] p_tag, p_ftag;

  rt_stage_if #(.C_RT_NUM(N), .C_ARCH_IDX_WIDTH(AW), .C_TAG_IDX_WIDTH(TW)) bus ();

  rt_stage #(.C_RT_NUM(N), .C_ARCH_IDX_WIDTH(AW), .C_TAG_IDX_WIDTH(TW)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .rt    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    blocked = -1;
    m_cnt   = '0;
    p_wr    = '0;
    p_fl    = '0;
    p_rd    = '0;
    p_tag   = '0;
    p_ftag  = '0;
  endtask

  task automatic set_inputs(input logic [1:0] v, input logic [1:0] c, input logic [1:0] m,
                            input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                            input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                            input logic [TW-1:0] o0, input logic [TW-1:0] o1, input logic e);
    bus.rob_valid_i      = v;
    bus.rob_complete_i   = c;
    bus.rob_br_mispred_i = m;
    bus.rob_rd_i         = {r1, r0};
    bus.rob_tag_i        = {t1, t0};
    bus.rob_tag_old_i    = {o1, o0};
    bus.rob_empty_i      = e;
  endtask

  // One cycle: record what the registered outputs must show now, then apply new inputs.
  task automatic drive(input logic [1:0] v, input logic [1:0] c, input logic [1:0] m,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                       input logic [TW-1:0] o0, input logic [TW-1:0] o1, input logic e);
    exp_t          x;
    int            n;
    int            last[int];
    logic [AW-1:0] rd_a[2];
    @(posedge clk);
    #1;
    x.wr   = p_wr;
    x.fl   = p_fl;
    x.rd   = p_rd;
    x.tag  = p_tag;
    x.ftag = p_ftag;
    x.cnt  = m_cnt;
    x.rb   = (blocked == 2);
    set_inputs(v, c, m, r0, r1, t0, t1, o0, o1, e);
    rd_a[0] = r0;
    rd_a[1] = r1;
    n = 0;
    if (blocked < 0) begin
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && c[i])) break;
        n++;
        if (m[i]) break;
      end
    end
    x.num = 2'(n);
    p_wr = '0;
    p_fl = '0;
    for (int i = 0; i < n; i++) begin
      if (rd_a[i] != 0) begin
        p_fl[i] = 1'b1;
        last[int'(rd_a[i])] = i;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (rd_a[i] != 0 && last[int'(rd_a[i])] == i) p_wr[i] = 1'b1;
    end
    p_rd   = {r1, r0};
    p_tag  = {t1, t0};
    p_ftag = {o1, o0};
    m_cnt  = m_cnt + 32'(n);
    if (blocked < 0) begin
      if (n > 0 && m[n-1]) blocked = 1;
    end else if (blocked < 3) begin
      blocked++;
    end else if (e) begin
      blocked = -1;
    end
    exp_q.push_back(x);
  endtask

  task automatic drive_idle(input logic e);
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0, e);
  endtask

  task automatic drive_rand();
    logic [1:0] v, c, m;
    v = 2'($urandom_range(1, 3));
    c = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
    m = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
    drive(v, c, m, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
          TW'($urandom), TW'($urandom), TW'($urandom), TW'($urandom),
          ($urandom_range(0, 3) == 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_num"},  32'(bus.rt_retire_num_o),  0);
    check({tag, "_wr"},   32'(bus.rt_amt_wr_en_o),   0);
    check({tag, "_fl"},   32'(bus.rt_fl_valid_o),    0);
    check({tag, "_rb"},   32'(bus.rollback_o),       0);
    check({tag, "_cnt"},  bus.rt_retired_cnt_o,      0);
    check({tag, "_rd"},   32'(bus.rt_amt_rd_o),      0);
    check({tag, "_tag"},  32'(bus.rt_amt_tag_o),     0);
    check({tag, "_ftag"}, 32'(bus.rt_fl_tag_o),      0);
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check("retire_num", 32'(bus.rt_retire_num_o), 32'(x.num));
      check("amt_wr_en",  32'(bus.rt_amt_wr_en_o),  32'(x.wr));
      check("fl_valid",   32'(bus.rt_fl_valid_o),   32'(x.fl));
      check("rollback",   32'(bus.rollback_o),      32'(x.rb));
      check("retired_cnt", bus.rt_retired_cnt_o,    x.cnt);
      for (int i = 0; i < N; i++) begin
        if (x.wr[i]) begin
          check("amt_rd",  32'(bus.rt_amt_rd_o[i]),  32'(x.rd[i]));
          check("amt_tag", 32'(bus.rt_amt_tag_o[i]), 32'(x.tag[i]));
        end
        if (x.fl[i]) check("fl_tag", 32'(bus.rt_fl_tag_o[i]), 32'(x.ftag[i]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();

    // Reset with a fully retirable head must still show nothing retiring.
    rst_n = 1'b0;
    set_inputs(2'b11, 2'b11, 2'b00, 5'd3, 5'd4, 6'd12, 6'd13, 6'd5, 6'd6, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("por");
    set_inputs('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(2'b11, 2'b11, 2'b00, 5'd3, 5'd4, 6'd12, 6'd13, 6'd5, 6'd6, 1'b0);
    drive(2'b11, 2'b10, 2'b00, 5'd1, 5'd2, 6'd1, 6'd2, 6'd3, 6'd4, 1'b0);
    drive(2'b11, 2'b01, 2'b00, 5'd1, 5'd2, 6'd7, 6'd8, 6'd9, 6'd10, 1'b0);
    drive(2'b11, 2'b11, 2'b00, 5'd7, 5'd7, 6'd20, 6'd21, 6'd9, 6'd20, 1'b0);
    drive(2'b11, 2'b11, 2'b00, 5'd0, 5'd6, 6'd40, 6'd41, 6'd42, 6'd43, 1'b0);
    // Mispredict on lane 0; empty during WB/ROLLBACK must be ignored.
    drive(2'b11, 2'b11, 2'b01, 5'd2, 5'd5, 6'd30, 6'd31, 6'd1, 6'd2, 1'b0);
    drive(2'b11, 2'b11, 2'b00, 5'd8, 5'd9, 6'd32, 6'd33, 6'd3, 6'd4, 1'b1);
    drive(2'b11, 2'b11, 2'b00, 5'd8, 5'd9, 6'd32, 6'd33, 6'd3, 6'd4, 1'b1);
    drive(2'b11, 2'b11, 2'b00, 5'd8, 5'd9, 6'd32, 6'd33, 6'd3, 6'd4, 1'b0);
    drive(2'b11, 2'b11, 2'b00, 5'd8, 5'd9, 6'd32, 6'd33, 6'd3, 6'd4, 1'b0);
    drive(2'b11, 2'b11, 2'b00, 5'd8, 5'd9, 6'd32, 6'd33, 6'd3, 6'd4, 1'b1);
    drive(2'b11, 2'b11, 2'b00, 5'd10, 5'd11, 6'd34, 6'd35, 6'd5, 6'd6, 1'b0);
    drive_idle(1'b0);

    for (int k = 0; k < 400; k++) drive_rand();

    // Reach RECOVER, then reset in the middle of it.
    drive(2'b01, 2'b01, 2'b01, 5'd12, 5'd0, 6'd50, 6'd0, 6'd51, 6'd0, 1'b0);
    for (int k = 0; k < 4; k++) drive(2'b11, 2'b11, 2'b00, 5'd13, 5'd14, 6'd1, 6'd2, 6'd3, 6'd4, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid");
    @(posedge clk);
    #2;
    check_reset_outputs("hold");
    set_inputs('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    drive(2'b11, 2'b11, 2'b00, 5'd15, 5'd16, 6'd60, 6'd61, 6'd62, 6'd63, 1'b0);
    drive(2'b11, 2'b11, 2'b00, 5'd17, 5'd18, 6'd10, 6'd11, 6'd12, 6'd13, 1'b0);
    for (int k = 0; k < 200; k++) drive_rand();
    drive_idle(1'b1);
    drive_idle(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rt_stage.md
# rt_stage

Retire stage that sits between the reorder buffer head and the architectural map table (AMT). It is the writer side of the AMT update/rollback interface. Each cycle it retires up to C_RT_NUM in-order completed head entries, produces registered AMT write packets and free-list returns, and sequences the rollback pulse when a mispredicted branch retires. It then blocks retirement until the ROB reports empty.

## Interface
- C_RT_NUM, 2, retire lanes per cycle (lane 0 = oldest)
- C_ARCH_IDX_WIDTH, 5, architectural register index width (32 entries)
- C_TAG_IDX_WIDTH, 6, physical tag width
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- rob_valid_i  in  C_RT_NUM  head lane i holds a valid entry
- rob_complete_i  in  C_RT_NUM  lane i has finished execution
- rob_br_mispred_i  in  C_RT_NUM  lane i is a resolved mispredicted branch
- rob_rd_i  in  C_RT_NUM×C_ARCH_IDX_WIDTH  destination arch register
- rob_tag_i  in  C_RT_NUM×C_TAG_IDX_WIDTH  new physical tag
- rob_tag_old_i  in  C_RT_NUM×C_TAG_IDX_WIDTH  previous mapping of rd
- rob_empty_i  in  1  ROB holds no entries
- rt_retire_num_o  out  clog2(C_RT_NUM+1)  entries popped from ROB head this cycle (combinational)
- rt_amt_wr_en_o  out  C_RT_NUM  AMT write enable per lane (registered)
- rt_amt_rd_o  out  C_RT_NUM×C_ARCH_IDX_WIDTH  AMT write index (registered)
- rt_amt_tag_o  out  C_RT_NUM×C_TAG_IDX_WIDTH  AMT write data (registered)
- rt_fl_valid_o  out  C_RT_NUM  free-list return valid (registered)
- rt_fl_tag_o  out  C_RT_NUM×C_TAG_IDX_WIDTH  tag returned to free list (registered)
- rollback_o  out  1  AMT/map-table rollback pulse (registered, Moore)
- rt_retired_cnt_o  out  32  total retired instructions (registered)

## Operation
- FSM states: RUN, WB, ROLLBACK, RECOVER. Reset state is RUN.
- Retirement in RUN only. Lane i retires iff, for every j≤i, lane j is valid and complete, and no lane j<i is mispredicted.
- A mispredicted lane itself retires. All younger lanes are blocked.
- rt_retire_num_o is the count of retiring lanes. It is contiguous from lane 0 and is 0 in any state other than RUN.
- For each retiring lane i with rd≠0:
  - amt_wr_en[i]=1, amt_rd[i]=rd, amt_tag[i]=tag.
  - fl_valid[i]=1, fl_tag[i]=tag_old.
- rd=0: the lane retires (it is counted) but amt_wr_en[i]=0 and fl_valid[i]=0.
- Same rd in two retiring lanes: only the youngest lane keeps amt_wr_en. Older lanes' AMT writes are suppressed, but all free-list returns are still issued.
- Transitions:
  - RUN→WB when any retiring lane is mispredicted.
  - WB→ROLLBACK unconditionally.
  - ROLLBACK→RECOVER unconditionally.
  - RECOVER→RUN when rob_empty_i=1.
- rollback_o=1 iff state==ROLLBACK.
- rt_retired_cnt_o += rt_retire_num_o every cycle. It wraps modulo 2^32.
- Non-retiring cycles drive all wr_en/fl_valid to 0. The rd/tag payload is don't-care.

## Timing
- Retire decision in cycle N (combinational from rob_* inputs and state). AMT/free-list outputs are visible in cycle N+1, for exactly one cycle.
- Mispredict retired in cycle N:
  - N+1: state WB; the branch's AMT write is visible. rollback_o=0.
  - N+2: state ROLLBACK; rollback_o=1, single cycle. The AMT already contains the branch's mapping.
  - N+3 onward: RECOVER; rt_retire_num_o=0.
  - If rob_empty_i=1 is sampled in cycle M, state is RUN in M+1 and retirement may occur in M+1.
- rob_empty_i during WB/ROLLBACK is ignored.
- Reset assertion mid-operation immediately:
  - forces RUN;
  - clears all registered outputs (wr_en, fl_valid, rd, tags, rollback_o) and rt_retired_cnt_o to 0.
  - rt_retire_num_o becomes 0 while reset is asserted.
- No back-pressure from AMT or free list. Outputs are never held.

## Test plan
- Reset → rt_amt_wr_en_o=0, rt_fl_valid_o=0, rollback_o=0, rt_retired_cnt_o=0, rt_retire_num_o=0 even with valid/complete inputs.
- Both lanes valid+complete, lane0 rd=3 tag=12 old=5, lane1 rd=4 tag=13 old=6 → retire_num=2. Next cycle: wr_en=2'b11, rd={4,3}, tag={13,12}, fl_tag={6,5}, cnt=2.
- Lane0 not complete, lane1 complete → retire_num=0 and no writes. Lane0 complete, lane1 not → retire_num=1, only lane0 written.
- Lane0 rd=7 tag=20 old=9, lane1 rd=7 tag=21 old=20 → wr_en=2'b10 (tag 21), fl_valid=2'b11 returning {20,9}. Lane with rd=0 → counted, no write or free.
- Lane0 mispredicted rd=2 tag=30, lane1 valid+complete:
  - retire_num=1; N+1 shows AMT write tag 30; N+2 rollback_o=1.
  - retire_num=0 until rob_empty_i=1; retirement resumes the next cycle.
- Reset asserted during RECOVER → all outputs 0. After release, state RUN and retirement proceeds without waiting for rob_empty_i.
